// File: rtl/ib_sequencer_if.sv
// Load-stream, IB-port and datapath handshake bundle between the IB sequencer and its surroundings.
// The master modport is the sequencer's view; slave is the IB/datapath/stream-source side.
interface ib_sequencer_if #(
    parameter int ADDR_BITS = 10,
    parameter int INST_BITS = 128
);
    logic                 s_valid;
    logic                 s_ready;
    logic [INST_BITS-1:0] s_data;

    logic                 ib_wea;
    logic [ADDR_BITS-1:0] ib_addra;
    logic [INST_BITS-1:0] ib_din;

    logic                 ib_en;
    logic                 ib_mode;
    logic                 ib_incr;
    logic                 ib_jmp;
    logic                 ib_flag;
    logic [ADDR_BITS-1:0] ib_start_addr;
    logic [ADDR_BITS-1:0] ib_end_addr;
    logic                 ib_init_inst_pulse;

    logic                 exec_start;
    logic                 exec_done;

    modport master (
        input  s_valid, s_data, ib_init_inst_pulse, exec_done,
        output s_ready, ib_wea, ib_addra, ib_din,
               ib_en, ib_mode, ib_incr, ib_jmp, ib_flag,
               ib_start_addr, ib_end_addr, exec_start
    );

    modport slave (
        output s_valid, s_data, ib_init_inst_pulse, exec_done,
        input  s_ready, ib_wea, ib_addra, ib_din,
               ib_en, ib_mode, ib_incr, ib_jmp, ib_flag,
               ib_start_addr, ib_end_addr, exec_start
    );
endinterface

// File: rtl/ib_sequencer.sv
// Instruction-buffer sequencer: streams a program into IB memory, then runs it once or for N passes,
// handing each fetched instruction to the datapath through an exec_start/exec_done handshake.
module ib_sequencer #(
    parameter int ADDR_BITS = 10,
    parameter int INST_BITS = 128,
    parameter int LOOP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] cfg_start_addr,
    input  logic [ADDR_BITS-1:0] cfg_end_addr,
    input  logic                 cfg_mode,
    input  logic                 cfg_incr,
    input  logic [LOOP_BITS-1:0] cfg_loops,
    input  logic                 load,
    input  logic                 run,
    input  logic                 abort,
    ib_sequencer_if.master       bus,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [LOOP_BITS-1:0] pass_count
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_PRIME     = 4'd2;
    localparam logic [3:0] S_GAP       = 4'd3;
    localparam logic [3:0] S_FETCH     = 4'd4;
    localparam logic [3:0] S_WAIT_IB   = 4'd5;
    localparam logic [3:0] S_WAIT_EXEC = 4'd6;
    localparam logic [3:0] S_FINISH    = 4'd7;
    localparam logic [3:0] S_DRAIN     = 4'd8;

    localparam logic [ADDR_BITS:0]   IDX_ONE  = 1;
    localparam logic [LOOP_BITS-1:0] LOOP_ONE = 1;

    logic [3:0]           state, state_nxt;
    logic [ADDR_BITS:0]   len, idx, cfg_len;
    logic [LOOP_BITS-1:0] pass_tgt, tgt_nxt;
    logic                 cmd_accept, beat_take, inst_done;
    logic                 last_idx, last_pass, abort_take;

    // Length is one bit wider than the address so a full-memory program still fits.
    assign cfg_len    = {1'b0, cfg_end_addr} - {1'b0, cfg_start_addr} + IDX_ONE;
    assign tgt_nxt    = (cfg_mode && (cfg_loops != '0)) ? cfg_loops : LOOP_ONE;
    assign last_idx   = ((idx + IDX_ONE) == len);
    assign last_pass  = ((pass_count + LOOP_ONE) == pass_tgt);
    assign abort_take = abort && (state != S_IDLE) && (state != S_DRAIN);
    assign cmd_accept = (state == S_IDLE) && (load || run);
    assign beat_take  = (state == S_LOAD) && bus.s_valid && bus.s_ready && !abort_take;
    assign inst_done  = (state == S_WAIT_EXEC) && bus.exec_done && !abort_take;

    always_comb begin
        state_nxt = state;
        if (abort_take) begin
            state_nxt = S_DRAIN;
        end else begin
            case (state)
                S_IDLE:      if (load) state_nxt = S_LOAD;
                             else if (run) state_nxt = S_PRIME;
                S_LOAD:      if (beat_take && last_idx) state_nxt = S_IDLE;
                S_PRIME:     state_nxt = S_GAP;
                S_GAP:       state_nxt = S_FETCH;
                S_FETCH:     state_nxt = S_WAIT_IB;
                S_WAIT_IB:   if (bus.ib_init_inst_pulse) state_nxt = S_WAIT_EXEC;
                S_WAIT_EXEC: if (inst_done) state_nxt = (last_idx && last_pass) ? S_FINISH : S_GAP;
                S_FINISH:    state_nxt = S_IDLE;
                S_DRAIN:     state_nxt = S_IDLE;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    // Every output is a register decoded from the next state, so it lines up with the state it describes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            aborted           <= 1'b0;
            pass_count        <= '0;
            len               <= '0;
            idx               <= '0;
            pass_tgt          <= '0;
            bus.s_ready       <= 1'b0;
            bus.ib_wea        <= 1'b0;
            bus.ib_addra      <= '0;
            bus.ib_din        <= '0;
            bus.ib_en         <= 1'b0;
            bus.ib_mode       <= 1'b0;
            bus.ib_incr       <= 1'b0;
            bus.ib_jmp        <= 1'b0;
            bus.ib_flag       <= 1'b0;
            bus.ib_start_addr <= '0;
            bus.ib_end_addr   <= '0;
            bus.exec_start    <= 1'b0;
        end else begin
            state          <= state_nxt;
            busy           <= (state_nxt != S_IDLE);
            bus.s_ready    <= (state_nxt == S_LOAD);
            bus.ib_en      <= (state_nxt != S_IDLE) && (state_nxt != S_LOAD);
            bus.ib_flag    <= (state_nxt == S_PRIME) || (state_nxt == S_FETCH);
            bus.ib_jmp     <= (state_nxt == S_PRIME);
            bus.ib_wea     <= beat_take;
            // The PRIME read returns a stale word; its pulse lands in GAP and is dropped there.
            bus.exec_start <= (state == S_WAIT_IB) && (state_nxt == S_WAIT_EXEC);
            done           <= (state_nxt == S_FINISH) || (beat_take && last_idx);
            aborted        <= (state_nxt == S_DRAIN);

            if (cmd_accept) begin
                bus.ib_start_addr <= cfg_start_addr;
                bus.ib_end_addr   <= cfg_end_addr;
                bus.ib_mode       <= cfg_mode;
                bus.ib_incr       <= cfg_incr;
                len               <= cfg_len;
                pass_tgt          <= tgt_nxt;
                idx               <= '0;
                if (!load) pass_count <= '0;
            end

            if (beat_take) begin
                bus.ib_addra <= bus.ib_start_addr + idx[ADDR_BITS-1:0];
                bus.ib_din   <= INST_BITS'(bus.s_data);
                idx          <= last_idx ? '0 : idx + IDX_ONE;
            end

            // The IB counter wraps on its own between passes; only our bookkeeping restarts here.
            if (inst_done) begin
                idx <= last_idx ? '0 : idx + IDX_ONE;
                if (last_idx) pass_count <= pass_count + LOOP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ib_sequencer.sv
// Bench for ib_sequencer: a behavioural IB memory/counter and a fixed-latency datapath surround the DUT,
// and each scenario checks the executed instruction stream against an order computed from the program bounds.
module tb_ib_sequencer;
    localparam int AB = 10;
    localparam int IW = 32;
    localparam int LB = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AB-1:0] cfg_start_addr = '0, cfg_end_addr = '0;
    logic          cfg_mode = 1'b0, cfg_incr = 1'b0;
    logic [LB-1:0] cfg_loops = '0;
    logic          load = 1'b0, run = 1'b0, abort = 1'b0;
    logic          busy, done, aborted;
    logic [LB-1:0] pass_count;

    ib_sequencer_if #(.ADDR_BITS(AB), .INST_BITS(IW)) bus ();

    ib_sequencer #(.ADDR_BITS(AB), .INST_BITS(IW), .LOOP_BITS(LB)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
        .cfg_mode(cfg_mode), .cfg_incr(cfg_incr), .cfg_loops(cfg_loops),
        .load(load), .run(run), .abort(abort),
        .bus(bus),
        .busy(busy), .done(done), .aborted(aborted), .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IW-1:0] ref_mem [0:1023];
    logic [IW-1:0] exp_q [$];

    // IB model: memory, edge-triggered fetch counter that wraps between the bounds, one-cycle output pulse.
    logic [IW-1:0] ib_mem [0:1023];
    logic [AB-1:0] ib_ptr = '0;
    logic          ib_flag_q;
    logic [IW-1:0] ib_dout = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ib_flag_q <= 1'b0;
            bus.ib_init_inst_pulse <= 1'b0;
        end else begin
            if (bus.ib_wea) ib_mem[bus.ib_addra] <= bus.ib_din;
            bus.ib_init_inst_pulse <= 1'b0;
            if (bus.ib_en) begin
                ib_flag_q <= bus.ib_flag;
                if (bus.ib_flag && !ib_flag_q) begin
                    ib_dout <= ib_mem[ib_ptr];
                    bus.ib_init_inst_pulse <= 1'b1;
                    if (bus.ib_jmp)
                        ib_ptr <= bus.ib_incr ? bus.ib_start_addr : bus.ib_end_addr;
                    else if (bus.ib_incr)
                        ib_ptr <= (ib_ptr == bus.ib_end_addr) ? bus.ib_start_addr : ib_ptr + 1'b1;
                    else
                        ib_ptr <= (ib_ptr == bus.ib_start_addr) ? bus.ib_end_addr : ib_ptr - 1'b1;
                end
            end
        end
    end

    // Datapath model and event log, sampled on the falling edge.
    logic [IW-1:0] got_q [$];
    logic [AB-1:0] wr_addr_q [$];
    logic [IW-1:0] wr_data_q [$];
    int done_cnt = 0, abort_cnt = 0, flag_viol = 0, dp_cnt = 0;
    logic flag_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            bus.exec_done = 1'b0;
            dp_cnt = 0;
            flag_prev = 1'b0;
        end else begin
            bus.exec_done = 1'b0;
            if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) bus.exec_done = 1'b1;
            end
            if (bus.exec_start) begin
                got_q.push_back(ib_dout);
                dp_cnt = 3;
            end
            if (bus.ib_wea) begin
                wr_addr_q.push_back(bus.ib_addra);
                wr_data_q.push_back(bus.ib_din);
            end
            if (done) done_cnt++;
            if (aborted) abort_cnt++;
            if (bus.ib_flag && flag_prev) flag_viol++;
            flag_prev = bus.ib_flag;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic stream_beats(input int s, input int n, input bit gapped, output int got);
        int cyc;
        logic [IW-1:0] pend;
        cyc = 0;
        got = 0;
        pend = $urandom;
        while (got < n && cyc < 200) begin
            bus.s_valid = (!gapped || cyc[0]);
            bus.s_data  = pend;
            if (bus.s_valid && bus.s_ready) begin
                ref_mem[s + got] = pend;
                got++;
                pend = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic do_load(input int s, input int e, input bit gapped, output int got);
        cfg_start_addr = AB'(s);
        cfg_end_addr   = AB'(e);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        stream_beats(s, e - s + 1, gapped, got);
        tick(2);
    endtask

    task automatic do_run(input int s, input int e, input bit mode, input bit incr,
                          input int loops, output bit finished);
        cfg_start_addr = AB'(s);
        cfg_end_addr   = AB'(e);
        cfg_mode  = mode;
        cfg_incr  = incr;
        cfg_loops = LB'(loops);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            if (done) finished = 1'b1;
            else @(negedge clk);
        end
        tick(2);
    endtask

    // Expected execution order straight from the program rules: each pass walks start..end or end..start.
    function automatic void build_exp(input int s, input int e, input bit mode, input bit incr, input int loops);
        int passes;
        passes = (mode && loops != 0) ? loops : 1;
        exp_q.delete();
        for (int p = 0; p < passes; p++)
            for (int k = 0; k <= e - s; k++)
                exp_q.push_back(ref_mem[incr ? s + k : e - k]);
    endfunction

    task automatic test_reset();
        tick(2);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
        n_checks++; if (bus.ib_en !== 1'b0) begin n_fail++; $display("FAIL reset_ib_en: got %b expected 0", bus.ib_en); end
        n_checks++; if (bus.ib_wea !== 1'b0) begin n_fail++; $display("FAIL reset_ib_wea: got %b expected 0", bus.ib_wea); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (pass_count !== '0) begin n_fail++; $display("FAIL reset_pass_count: got %0d expected 0", pass_count); end
        reset_n = 1'b1;
        tick(2);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
        n_checks++; if (bus.ib_flag !== 1'b0) begin n_fail++; $display("FAIL idle_ib_flag: got %b expected 0", bus.ib_flag); end
        n_checks++; if (bus.exec_start !== 1'b0) begin n_fail++; $display("FAIL idle_exec_start: got %b expected 0", bus.exec_start); end
    endtask

    task automatic test_load();
        int wbase, dbase, got;
        wbase = wr_addr_q.size();
        dbase = done_cnt;
        do_load(4, 7, 1'b1, got);
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL load_beats: got %0d expected 4", got); end
        n_checks++; if (wr_addr_q.size() - wbase !== 4) begin n_fail++; $display("FAIL load_writes: got %0d expected 4", wr_addr_q.size() - wbase); end
        for (int k = 0; k < 4 && wbase + k < wr_addr_q.size(); k++) begin
            n_checks++; if (wr_addr_q[wbase + k] !== AB'(4 + k)) begin n_fail++; $display("FAIL load_addr[%0d]: got %0d expected %0d", k, wr_addr_q[wbase + k], 4 + k); end
            n_checks++; if (wr_data_q[wbase + k] !== ref_mem[4 + k]) begin n_fail++; $display("FAIL load_data[%0d]: got %h expected %h", k, wr_data_q[wbase + k], ref_mem[4 + k]); end
        end
        n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL load_done: got %0d pulses expected 1", done_cnt - dbase); end
        n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL load_s_ready_after: got %b expected 0", bus.s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_procedural();
        int gbase, dbase, fbase;
        bit fin;
        gbase = got_q.size(); dbase = done_cnt; fbase = flag_viol;
        build_exp(4, 7, 1'b0, 1'b1, 0);
        do_run(4, 7, 1'b0, 1'b1, 5, fin);
        n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL proc_finish: got %b expected 1 (timeout)", fin); end
        n_checks++; if (got_q.size() - gbase !== exp_q.size()) begin n_fail++; $display("FAIL proc_exec_count: got %0d expected %0d", got_q.size() - gbase, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && gbase + k < got_q.size(); k++) begin
            n_checks++; if (got_q[gbase + k] !== exp_q[k]) begin n_fail++; $display("FAIL proc_inst[%0d]: got %h expected %h", k, got_q[gbase + k], exp_q[k]); end
        end
        n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL proc_done: got %0d pulses expected 1", done_cnt - dbase); end
        n_checks++; if (pass_count !== LB'(1)) begin n_fail++; $display("FAIL proc_pass_count: got %0d expected 1", pass_count); end
        n_checks++; if (flag_viol - fbase !== 0) begin n_fail++; $display("FAIL proc_flag_gap: got %0d back-to-back flag cycles expected 0", flag_viol - fbase); end
        n_checks++; if (bus.ib_en !== 1'b0) begin n_fail++; $display("FAIL proc_ib_en_after: got %b expected 0", bus.ib_en); end
    endtask

    task automatic test_wrap_decr();
        int gbase, dbase, got;
        bit fin;
        do_load(0, 2, 1'b0, got);
        gbase = got_q.size(); dbase = done_cnt;
        build_exp(0, 2, 1'b1, 1'b0, 3);
        do_run(0, 2, 1'b1, 1'b0, 3, fin);
        n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL wrap_finish: got %b expected 1 (timeout)", fin); end
        n_checks++; if (got_q.size() - gbase !== 9) begin n_fail++; $display("FAIL wrap_exec_count: got %0d expected 9", got_q.size() - gbase); end
        for (int k = 0; k < exp_q.size() && gbase + k < got_q.size(); k++) begin
            n_checks++; if (got_q[gbase + k] !== exp_q[k]) begin n_fail++; $display("FAIL wrap_inst[%0d]: got %h expected %h", k, got_q[gbase + k], exp_q[k]); end
        end
        n_checks++; if (pass_count !== LB'(3)) begin n_fail++; $display("FAIL wrap_pass_count: got %0d expected 3", pass_count); end
        n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL wrap_done: got %0d pulses expected 1", done_cnt - dbase); end
    endtask

    task automatic test_single();
        int gbase, dbase, got;
        bit fin;
        do_load(5, 5, 1'b0, got);
        gbase = got_q.size(); dbase = done_cnt;
        do_run(5, 5, 1'b1, 1'b1, 0, fin);
        n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL single_finish: got %b expected 1 (timeout)", fin); end
        n_checks++; if (got_q.size() - gbase !== 1) begin n_fail++; $display("FAIL single_exec_count: got %0d expected 1", got_q.size() - gbase); end
        if (got_q.size() > gbase) begin
            n_checks++; if (got_q[gbase] !== ref_mem[5]) begin n_fail++; $display("FAIL single_inst: got %h expected %h", got_q[gbase], ref_mem[5]); end
        end
        n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL single_done: got %0d pulses expected 1", done_cnt - dbase); end
        n_checks++; if (pass_count !== LB'(1)) begin n_fail++; $display("FAIL single_pass_count: got %0d expected 1", pass_count); end
    endtask

    task automatic test_abort();
        int gbase, dbase, abase, seen;
        bit fin;
        dbase = done_cnt; abase = abort_cnt;
        cfg_start_addr = AB'(4); cfg_end_addr = AB'(7);
        cfg_mode = 1'b0; cfg_incr = 1'b1;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        seen = 0;
        for (int i = 0; i < 500 && seen < 2; i++) begin
            @(negedge clk);
            if (bus.exec_start) seen++;
        end
        n_checks++; if (seen !== 2) begin n_fail++; $display("FAIL abort_reach_exec: got %0d starts expected 2 (timeout)", seen); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b expected 1", aborted); end
        n_checks++; if (bus.ib_en !== 1'b1) begin n_fail++; $display("FAIL drain_ib_en: got %b expected 1", bus.ib_en); end
        n_checks++; if (bus.ib_flag !== 1'b0) begin n_fail++; $display("FAIL drain_ib_flag: got %b expected 0", bus.ib_flag); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy: got %b expected 0", busy); end
        n_checks++; if (bus.ib_en !== 1'b0) begin n_fail++; $display("FAIL abort_idle_ib_en: got %b expected 0", bus.ib_en); end
        tick(6);
        n_checks++; if (done_cnt - dbase !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - dbase); end
        n_checks++; if (abort_cnt - abase !== 1) begin n_fail++; $display("FAIL abort_count: got %0d pulses expected 1", abort_cnt - abase); end
        gbase = got_q.size();
        build_exp(4, 7, 1'b0, 1'b1, 0);
        do_run(4, 7, 1'b0, 1'b1, 0, fin);
        n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL rerun_finish: got %b expected 1 (timeout)", fin); end
        n_checks++; if (got_q.size() - gbase !== exp_q.size()) begin n_fail++; $display("FAIL rerun_exec_count: got %0d expected %0d", got_q.size() - gbase, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && gbase + k < got_q.size(); k++) begin
            n_checks++; if (got_q[gbase + k] !== exp_q[k]) begin n_fail++; $display("FAIL rerun_inst[%0d]: got %h expected %h", k, got_q[gbase + k], exp_q[k]); end
        end
        n_checks++; if (pass_count !== LB'(1)) begin n_fail++; $display("FAIL rerun_pass_count: got %0d expected 1", pass_count); end
    endtask

    task automatic test_reset_midload();
        int got, dbase, abase, gbase;
        cfg_start_addr = AB'(8); cfg_end_addr = AB'(11);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        stream_beats(8, 2, 1'b0, got);
        dbase = done_cnt; abase = abort_cnt;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_s_ready: got %b expected 0", bus.s_ready); end
        n_checks++; if (bus.ib_wea !== 1'b0) begin n_fail++; $display("FAIL midreset_ib_wea: got %b expected 0", bus.ib_wea); end
        n_checks++; if (pass_count !== '0) begin n_fail++; $display("FAIL midreset_pass_count: got %0d expected 0", pass_count); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (done_cnt - dbase !== 0 || abort_cnt - abase !== 0) begin n_fail++; $display("FAIL midreset_no_pulse: got done %0d aborted %0d expected 0 0", done_cnt - dbase, abort_cnt - abase); end
        gbase = got_q.size();
        load = 1'b1; run = 1'b1;
        @(negedge clk);
        load = 1'b0; run = 1'b0;
        n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL both_s_ready: got %b expected 1", bus.s_ready); end
        n_checks++; if (bus.ib_en !== 1'b0 || bus.ib_flag !== 1'b0) begin n_fail++; $display("FAIL both_ib_idle: got en %b flag %b expected 0 0", bus.ib_en, bus.ib_flag); end
        stream_beats(8, 4, 1'b0, got);
        tick(4);
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL both_beats: got %0d expected 4", got); end
        n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL both_done: got %0d pulses expected 1", done_cnt - dbase); end
        n_checks++; if (got_q.size() - gbase !== 0) begin n_fail++; $display("FAIL both_run_ignored: got %0d exec starts expected 0", got_q.size() - gbase); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_busy_after: got %b expected 0", busy); end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_load();
        test_procedural();
        test_wrap_decr();
        test_single();
        test_abort();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ib_sequencer.md
Name: ib_sequencer

Overview:
Controller for the instruction buffer (IB). It streams a program into IB memory through the IB write port, then runs it. Running means configuring the IB and issuing single-cycle fetch flags. Each fetched instruction is handed to the systolic-array datapath with a start/done handshake. Programs run once (procedural) or for a programmed number of passes (wrap), forward or backward.

Parameters:
ADDR_BITS, 10, IB address width
INST_BITS, 128, instruction width
LOOP_BITS, 8, width of pass counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_start_addr  in  ADDR_BITS  first program address; must satisfy start<=end
cfg_end_addr  in  ADDR_BITS  last program address
cfg_mode  in  1  1 = wrap, 0 = procedural
cfg_incr  in  1  1 = ascending, 0 = descending
cfg_loops  in  LOOP_BITS  passes in wrap mode; 0 is treated as 1
load  in  1  pulse: begin program load at cfg_start_addr
run  in  1  pulse: begin execution
abort  in  1  pulse: stop any operation
s_valid  in  1  load stream valid
s_ready  out  1  load stream ready
s_data  in  INST_BITS  load stream instruction
ib_wea, ib_addra, ib_din  out  1/ADDR_BITS/INST_BITS  IB write port
ib_en, ib_mode, ib_incr, ib_jmp, ib_flag  out  1 each  IB control
ib_start_addr, ib_end_addr  out  ADDR_BITS  IB bounds
ib_init_inst_pulse  in  1  IB output-valid pulse
exec_start  out  1  one-cycle pulse: IB instruction output is valid for the datapath
exec_done  in  1  pulse: datapath finished the current instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: run completed normally
aborted  out  1  one-cycle pulse: abort taken
pass_count  out  LOOP_BITS  completed passes in the current or last run

Behaviour:
- All outputs are registered. Reset value is 0 for every output; the state machine resets to IDLE.
- Program length is LEN = end - start + 1, computed on ADDR_BITS+1 bits. Bounds, mode, direction and loops are latched at load/run acceptance. ib_start_addr, ib_end_addr, ib_mode and ib_incr drive the latched copies.
- IDLE: load takes priority over run when both are high; either is ignored outside IDLE.
- LOAD: s_ready = 1.
  - Each s_valid && s_ready cycle drives ib_wea = 1 next cycle, with ib_addra = start + idx and ib_din = s_data.
  - After LEN beats: s_ready drops in the same cycle as the last accepted beat, the FSM returns to IDLE, and done pulses.
- PRIME (on run): ib_en = 1, ib_jmp = 1, ib_flag = 1 for one cycle. This loads the IB counter with start (incr) or end (decr).
  - The instruction read in this cycle is stale: its init_inst_pulse is consumed and exec_start is not raised.
  - Then GAP.
- GAP: ib_flag = 0 for exactly one cycle, so the IB edge detector rearms. ib_jmp = 0. Then FETCH.
- FETCH: ib_flag = 1 for one cycle, then WAIT_IB.
- WAIT_IB: on ib_init_inst_pulse, exec_start pulses in the next cycle, then WAIT_EXEC. Fetch latency from flag to exec_start is 2 cycles.
- WAIT_EXEC: on exec_done, idx increments.
  - If idx reaches LEN: pass_count increments and idx clears. If pass_count reaches the target (target = 1 in procedural mode, else max(cfg_loops, 1)), go to FINISH. Otherwise go to GAP; the IB wraps by itself.
  - If idx has not reached LEN: go to GAP.
- exec_done outside WAIT_EXEC is ignored.
- FINISH: done pulses, ib_en = 0, then IDLE. pass_count holds until the next run.
- ib_en = 1 in PRIME..FINISH only.
- Abort from any non-IDLE state goes to DRAIN:
  - ib_flag = 0, ib_wea = 0, s_ready = 0, ib_en held at 1 for one cycle so the IB flag FF clears.
  - aborted pulses, then IDLE.
- Abort in IDLE is ignored. Abort has priority over every other transition in the same cycle.
- Asynchronous reset mid-run returns immediately to IDLE with all outputs 0. No done or aborted pulse is generated.

Test Plan:
- Load start=4, end=7 with 4 beats; s_valid gapped every other cycle -> ib_wea at addresses 4,5,6,7 with matching data; done after beat 4; s_ready = 0 after.
- Procedural incr run, start=4, end=7, exec_done 3 cycles after each exec_start -> exactly 4 exec_start pulses presenting instructions 4,5,6,7; the stale PRIME instruction is suppressed; ib_flag pulses are separated by >=1 low cycle; done pulses; pass_count = 1.
- Wrap decr, start=0, end=2, cfg_loops=3 -> 9 exec_start pulses with order 2,1,0 ×3; pass_count = 3; done pulses once.
- start=end=5, cfg_loops=0, wrap -> a single instruction executes once; done pulses.
- abort during WAIT_EXEC, then a new run -> aborted pulses, one DRAIN cycle with ib_en = 1 and ib_flag = 0, no done pulse; the next run executes correctly from start.
- reset_n low mid-LOAD, then load and run together in IDLE -> outputs 0 immediately during reset; LOAD entered; run ignored.
